// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  // MEM result is younger than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic rs_used,
                                         input logic [4:0] rd_m, input logic [2:0] wr_m,
                                         input logic [4:0] rd_w, input logic [2:0] wr_w);
    if (rs_used && (wr_m != 3'd0) && (rd_m != 5'd0) && (rd_m == rs)) return FWD_MEM;
    if (rs_used && (wr_w != 3'd0) && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage operand info in, segment controls out.
interface hazard_ctrl_if;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  RegReadD, RegReadE;
  logic [2:0]  RegWriteM, RegWriteW;
  logic        MemToRegE, BranchE, JalrE, JalD, MissM, MemReadyM;
  logic        StallF, FlushF, StallD, FlushD, StallE, FlushE;
  logic        StallM, FlushM, StallW, FlushW;
  logic [1:0]  Forward1E, Forward2E;
  logic [31:0] StallCycles, FlushCount;
  logic        MemTimeout;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegReadD, RegReadE, RegWriteM, RegWriteW,
           MemToRegE, BranchE, JalrE, JalD, MissM, MemReadyM,
    input  StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW,
           Forward1E, Forward2E, StallCycles, FlushCount, MemTimeout
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegReadD, RegReadE, RegWriteM, RegWriteW,
           MemToRegE, BranchE, JalrE, JalD, MissM, MemReadyM,
    output StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW,
           Forward1E, Forward2E, StallCycles, FlushCount, MemTimeout
  );
endinterface

// File: rtl/hazard_ctrl_perf_counter.sv
// Saturating event counter with synchronous clear.
module hazard_ctrl_perf_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [Width-1:0] o_count
);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: cache-miss wait FSM, load-use/branch stalls and flushes, forwarding.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  state_e     r_state, w_state_d;
  logic [7:0] r_wait, w_wait_d;
  logic       r_timeout, w_timeout_d;
  logic       w_mem_stall, w_load_use, w_redirect, w_any_stall, w_flush_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_wait    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_wait    <= w_wait_d;
      r_timeout <= w_timeout_d;
    end
  end

  // Timeout only raises a flag; the FSM keeps waiting for the refill.
  always_comb begin
    w_state_d   = r_state;
    w_wait_d    = r_wait;
    w_timeout_d = r_timeout;
    case (r_state)
      RUN: begin
        if (hz.MissM && !hz.MemReadyM) begin
          w_state_d = MEM_WAIT;
          w_wait_d  = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (hz.MemReadyM) begin
          w_state_d = RUN;
        end else if (r_wait != TIMEOUT_LIMIT) begin
          w_wait_d = r_wait + 8'd1;
          if (r_wait == TIMEOUT_LIMIT - 8'd1) w_timeout_d = 1'b1;
        end
      end
      default: w_state_d = RUN;
    endcase
  end

  assign w_mem_stall = ((r_state == RUN) && hz.MissM && !hz.MemReadyM) ||
                       ((r_state == MEM_WAIT) && !hz.MemReadyM);
  assign w_load_use  = hz.MemToRegE && (hz.RdE != 5'd0) &&
                       (((hz.RdE == hz.Rs1D) && hz.RegReadD[1]) ||
                        ((hz.RdE == hz.Rs2D) && hz.RegReadD[0]));
  assign w_redirect  = hz.BranchE || hz.JalrE;

  always_comb begin
    {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW} = 5'b00000;
    {hz.FlushF, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW} = 5'b00000;
    if (rst) begin
      {hz.FlushF, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW} = 5'b11111;
    end else if (w_mem_stall) begin
      {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW} = 5'b11111;
    end else if (w_redirect) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (w_load_use) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (hz.JalD) begin
      hz.FlushD = 1'b1;
    end
  end

  always_comb begin
    hz.Forward1E = FWD_RF;
    hz.Forward2E = FWD_RF;
    if (!rst) begin
      hz.Forward1E = fwd_sel(hz.Rs1E, hz.RegReadE[1], hz.RdM, hz.RegWriteM, hz.RdW,
                             hz.RegWriteW);
      hz.Forward2E = fwd_sel(hz.Rs2E, hz.RegReadE[0], hz.RdM, hz.RegWriteM, hz.RdW,
                             hz.RegWriteW);
    end
  end

  assign w_any_stall   = hz.StallF | hz.StallD | hz.StallE | hz.StallM | hz.StallW;
  assign w_flush_evt   = !rst && !w_mem_stall && w_redirect;
  assign hz.MemTimeout = r_timeout;

  hazard_ctrl_perf_counter #(
    .Width (32)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_any_stall),
    .i_clear (1'b0),
    .o_count (hz.StallCycles)
  );

  hazard_ctrl_perf_counter #(
    .Width (32)
  ) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_flush_evt),
    .i_clear (1'b0),
    .o_count (hz.FlushCount)
  );

endmodule
